// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
//
// Serial PRBS31 (x^31 + x^28 + 1) receive checker. It synchronises itself to an
// incoming bit stream and declares lock. After lock it counts bit errors in a
// saturating counter. It drops lock when too many errors arrive inside one
// window, so that it can re-acquire after a bit slip.
//
// State progression:
//   HUNT   : loads 31 received bits into the reference register.
//   SYNC   : keeps loading received bits and predicts each new bit. It needs
//            LOCK_CNT consecutive correct predictions to enter LOCKED. An
//            all-zero register sends it back to HUNT, so a zero stream never
//            locks.
//   LOCKED : the reference runs freely on its own predictions. Each line error
//            is therefore counted exactly once. Reaching LOSS_ERRS errors
//            inside one LOSS_WIN-bit window drops back to HUNT.
//
// Parameters:
//   LOCK_CNT  : consecutive correct predictions in SYNC needed to lock (>= 1)
//   LOSS_WIN  : error-window length in valid bits while LOCKED (>= 2)
//   LOSS_ERRS : errors within one window that force loss of lock (1..LOSS_WIN)
//   ERR_W     : width of err_count_o
//
// Ports:
//   clk_i         clock; all state changes on the rising edge
//   rst_n_i       synchronous active-low reset
//   bit_in_i      received serial bit; sampled only when bit_valid_i = 1
//   bit_valid_i   qualifies bit_in_i; cycles without it change no lock state
//   clr_errs_i    synchronous clear of err_count_o (wins over an increment)
//   locked_o      1 while the checker is in LOCKED
//   state_o       2'b00 HUNT, 2'b01 SYNC, 2'b10 LOCKED
//   err_pulse_o   one-cycle pulse after an errored valid bit in LOCKED
//   err_count_o   saturating count of errored bits seen in LOCKED
// -----------------------------------------------------------------------------
module prbs31_checker #(
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned LOSS_WIN  = 64,
    parameter int unsigned LOSS_ERRS = 8,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             bit_in_i,
    input  logic             bit_valid_i,
    input  logic             clr_errs_i,
    output logic             locked_o,
    output logic [1:0]       state_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o
);

    // Counter widths. The match and window-error counters must be able to
    // hold their terminal values. The window counter only needs 0..LOSS_WIN-1.
    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(LOSS_WIN);
    localparam int unsigned EW = $clog2(LOSS_ERRS + 1);

    // Each counter is compared against the value it holds just before its
    // terminal event. The terminal transition then happens on the same edge
    // that consumes the deciding bit.
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WIN - 1);
    localparam logic [EW-1:0] ERRS_LAST = EW'(LOSS_ERRS - 1);
    localparam logic [4:0]    FILL_LAST = 5'd30;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    // Next bit predicted from the last 31 bits: b[n] = b[n-31] ^ b[n-28].
    function automatic logic prbs31_predict(input logic [30:0] sr);
        return sr[30] ^ sr[27];
    endfunction

    // Counter increment that holds at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == {ERR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + ERR_W'(1);
        end
        return r;
    endfunction

    state_e           state_q,     state_d;
    logic [30:0]      sr_q,        sr_d;
    logic [4:0]       fill_q,      fill_d;
    logic [MW-1:0]    match_q,     match_d;
    logic [WW-1:0]    win_q,       win_d;
    logic [EW-1:0]    winerr_q,    winerr_d;
    logic             locked_q,    locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             pred_s;
    logic             err_s;
    logic [30:0]      sr_load_s;
    logic [30:0]      sr_free_s;

    // Prediction and error detection for the current input bit.
    always_comb begin
        pred_s    = prbs31_predict(sr_q);
        err_s     = bit_in_i ^ pred_s;
        sr_load_s = {sr_q[29:0], bit_in_i};
        sr_free_s = {sr_q[29:0], pred_s};
    end

    // Next-state logic for the acquisition/lock FSM, the counters and the outputs.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        winerr_d    = winerr_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (bit_valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    sr_d = sr_load_s;
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_SYNC;
                        fill_d  = 5'd0;
                        match_d = '0;
                    end else begin
                        fill_d  = fill_q + 5'd1;
                    end
                end

                ST_SYNC: begin
                    sr_d = sr_load_s;
                    // A zero register predicts zeros forever. It would
                    // "lock" onto a dead line, so it takes priority over
                    // the match count.
                    if (sr_load_s == 31'd0) begin
                        state_d = ST_HUNT;
                        fill_d  = 5'd0;
                        match_d = '0;
                    end else if (err_s) begin
                        match_d = '0;
                    end else if (match_q == LOCK_LAST) begin
                        state_d  = ST_LOCKED;
                        match_d  = '0;
                        win_d    = '0;
                        winerr_d = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end

                ST_LOCKED: begin
                    // Free-running reference. A flipped line bit is never
                    // loaded, so it cannot cause follow-on errors.
                    sr_d = sr_free_s;
                    if (err_s) begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                    end else begin
                        err_count_d = err_count_q;
                    end

                    if (err_s && (winerr_q == ERRS_LAST)) begin
                        state_d  = ST_HUNT;
                        fill_d   = 5'd0;
                        win_d    = '0;
                        winerr_d = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d    = '0;
                        winerr_d = '0;
                    end else begin
                        win_d    = win_q + WW'(1);
                        winerr_d = winerr_q + EW'(err_s);
                    end
                end

                default: begin
                    state_d  = ST_HUNT;
                    sr_d     = 31'd0;
                    fill_d   = 5'd0;
                    match_d  = '0;
                    win_d    = '0;
                    winerr_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // The clear is applied after the increment, so it wins on the same cycle.
        if (clr_errs_i) begin
            err_count_d = '0;
        end else begin
            err_count_d = err_count_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, reference register, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_HUNT;
            sr_q        <= 31'd0;
            fill_q      <= 5'd0;
            match_q     <= '0;
            win_q       <= '0;
            winerr_q    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            winerr_q    <= winerr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked_o    = locked_q;
    assign state_o     = state_q;
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs31_checker
//
// Bench for prbs31_checker. It drives two instances from the same stimulus:
//   u_dut0 : default parameters (LOCK 64, window 64, 8 errors, 16-bit count)
//   u_dut1 : LOSS_ERRS = LOSS_WIN = 64 and a 4-bit error count
// A behavioural model follows both instances. Every cycle it is compared
// against the DUT outputs. Literal expectations at key points pin the model
// itself.
// -----------------------------------------------------------------------------
module tb_prbs31_checker;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        clr_errs;

    logic        lk0, ep0, lk1, ep1;
    logic [1:0]  st0, st1;
    logic [15:0] ec0;
    logic [3:0]  ec1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    prbs31_checker u_dut0 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .clr_errs_i  (clr_errs),
        .locked_o    (lk0),
        .state_o     (st0),
        .err_pulse_o (ep0),
        .err_count_o (ec0)
    );

    prbs31_checker #(
        .LOCK_CNT  (64),
        .LOSS_WIN  (64),
        .LOSS_ERRS (64),
        .ERR_W     (4)
    ) u_dut1 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .clr_errs_i  (clr_errs),
        .locked_o    (lk1),
        .state_o     (st1),
        .err_pulse_o (ep1),
        .err_count_o (ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 hunting, 1 synchronising, 2 locked.
    localparam int P_LOCK = 64;
    localparam int P_WIN  = 64;
    int p_errs[2] = '{8, 64};
    int p_cmax[2] = '{65535, 15};

    int m_state[2];
    int m_fill[2];
    int m_match[2];
    int m_win[2];
    int m_werr[2];
    int m_cnt[2];
    bit m_pulse[2];
    bit m_hist[2][31];   // m_hist[i][k]: reference bit from k+1 valid bits ago

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_fill[i] = 0; m_match[i] = 0;
            m_win[i] = 0; m_werr[i] = 0; m_cnt[i] = 0; m_pulse[i] = 1'b0;
            for (int k = 0; k < 31; k++) m_hist[i][k] = 1'b0;
        end
    endtask

    task automatic model_push(input int i, input bit b);
        for (int k = 30; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = b;
    endtask

    function automatic bit model_allzero(input int i);
        bit z;
        z = 1'b1;
        for (int k = 0; k < 31; k++) if (m_hist[i][k]) z = 1'b0;
        return z;
    endfunction

    task automatic model_step(input int i, input bit b, input bit v, input bit clr);
        bit p;
        bit e;
        p = m_hist[i][30] ^ m_hist[i][27];
        e = b ^ p;
        m_pulse[i] = 1'b0;
        if (v) begin
            if (m_state[i] == 0) begin
                model_push(i, b);
                m_fill[i]++;
                if (m_fill[i] == 31) begin
                    m_state[i] = 1;
                    m_match[i] = 0;
                end
            end else if (m_state[i] == 1) begin
                model_push(i, b);
                if (model_allzero(i)) begin
                    m_state[i] = 0;
                    m_fill[i]  = 0;
                end else if (e) begin
                    m_match[i] = 0;
                end else begin
                    m_match[i]++;
                    if (m_match[i] == P_LOCK) begin
                        m_state[i] = 2;
                        m_win[i]   = 0;
                        m_werr[i]  = 0;
                    end
                end
            end else begin
                model_push(i, p);
                m_win[i]++;
                if (e) begin
                    m_pulse[i] = 1'b1;
                    if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
                    m_werr[i]++;
                end
                if (m_werr[i] >= p_errs[i]) begin
                    m_state[i] = 0;
                    m_fill[i]  = 0;
                end else if (m_win[i] == P_WIN) begin
                    m_win[i]  = 0;
                    m_werr[i] = 0;
                end
            end
        end
        if (clr) m_cnt[i] = 0;
    endtask

    // Advance the model on each rising edge using the inputs the DUTs see.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) model_step(i, bit_in, bit_valid, clr_errs);
        end
    end

    // Compare every output of both instances against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state0",  {30'd0, st0}, m_state[0]);
            chk("locked0", {31'd0, lk0}, {31'd0, m_state[0] == 2});
            chk("pulse0",  {31'd0, ep0}, {31'd0, m_pulse[0]});
            chk("count0",  {16'd0, ec0}, m_cnt[0]);
            chk("state1",  {30'd0, st1}, m_state[1]);
            chk("locked1", {31'd0, lk1}, {31'd0, m_state[1] == 2});
            chk("pulse1",  {31'd0, ep1}, {31'd0, m_pulse[1]});
            chk("count1",  {28'd0, ec1}, m_cnt[1]);
        end
    end

    // ---------------- stimulus ----------------
    logic [30:0] gen;

    function automatic bit gen_bit();
        bit b;
        b   = gen[30] ^ gen[27];
        gen = {gen[29:0], b};
        return b;
    endfunction

    task automatic tx_raw(input bit b, input bit v, input bit clr);
        bit_in    = b;
        bit_valid = v;
        clr_errs  = clr;
        @(negedge clk);
    endtask

    task automatic tx(input bit flip, input bit v, input bit clr);
        bit b;
        if (v) begin
            b = gen_bit() ^ flip;
        end else begin
            b = 1'($urandom);
        end
        tx_raw(b, v, clr);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        clr_errs  = 1'b0;
        gen       = 31'h7FFF_FFFF;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
    endtask

    // Feed a clean stream until u_dut0 locks; check the valid-bit count to lock.
    task automatic acquire(input string name, input int gap_pct);
        int nbits;
        int cyc;
        bit v;
        nbits = 0;
        cyc   = 0;
        while (!lk0 && cyc < 2000) begin
            v = ($urandom_range(99) >= gap_pct);
            tx(1'b0, v, 1'b0);
            if (v) nbits++;
            cyc++;
        end
        chk({name, "_lock_bits"}, nbits, 95);
        chk({name, "_locked0"}, {31'd0, lk0}, 32'd1);
        chk({name, "_locked1"}, {31'd0, lk1}, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int offs[8];
        int nerr;
        int gap;
        bit seen_lock;
        bit seen_sync;
        bit v;

        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clr_errs  = 1'b0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Reset values.
        chk("rst_state", {30'd0, st0}, 32'd0);
        chk("rst_locked", {31'd0, lk0}, 32'd0);
        chk("rst_pulse", {31'd0, ep0}, 32'd0);
        chk("rst_count", {16'd0, ec0}, 32'd0);

        // Clean stream, valid every cycle.
        acquire("t1", 0);
        chk("t1_count", {16'd0, ec0}, 32'd0);

        // A single inverted bit at window offset 9.
        for (int k = 0; k < 9; k++) tx(1'b0, 1'b1, 1'b0);
        tx(1'b1, 1'b1, 1'b0);
        chk("t2_pulse", {31'd0, ep0}, 32'd1);
        chk("t2_count", {16'd0, ec0}, 32'd1);
        chk("t2_state", {30'd0, st0}, 32'd2);
        tx(1'b0, 1'b1, 1'b0);
        chk("t2_pulse_end", {31'd0, ep0}, 32'd0);
        for (int k = 11; k < 64; k++) tx(1'b0, 1'b1, 1'b0);
        tx(1'b0, 1'b0, 1'b1);
        chk("t2_clear", {16'd0, ec0}, 32'd0);

        // Burst of 8 errors inside a single window.
        for (int j = 0; j < 8; j++) offs[j] = j * 5 + int'($urandom_range(4));
        nerr = 0;
        for (int k = 0; k < 40 && nerr < 8; k++) begin
            if (k == offs[nerr]) begin
                tx(1'b1, 1'b1, 1'b0);
                nerr++;
            end else begin
                tx(1'b0, 1'b1, 1'b0);
            end
        end
        chk("t3_state", {30'd0, st0}, 32'd0);
        chk("t3_locked", {31'd0, lk0}, 32'd0);
        chk("t3_count", {16'd0, ec0}, 32'd8);
        chk("t3_locked1", {31'd0, lk1}, 32'd1);
        chk("t3_count1", {28'd0, ec1}, 32'd8);
        acquire("t3_relock", 0);

        // Sparse errors saturate the 4-bit counter without losing lock.
        tx(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 20; j++) begin
            gap = 69 + int'($urandom_range(10));
            for (int k = 0; k < gap; k++) tx(1'b0, 1'b1, 1'b0);
            tx(1'b1, 1'b1, 1'b0);
        end
        chk("t5_count1_sat", {28'd0, ec1}, 32'd15);
        chk("t5_count0", {16'd0, ec0}, 32'd20);
        chk("t5_locked0", {31'd0, lk0}, 32'd1);
        tx(1'b1, 1'b1, 1'b1);
        chk("t5_clr_pri0", {16'd0, ec0}, 32'd0);
        chk("t5_clr_pri1", {28'd0, ec1}, 32'd0);
        chk("t5_clr_pulse", {31'd0, ep0}, 32'd1);

        // Constant zero input never locks and cycles HUNT/SYNC.
        do_reset();
        seen_lock = 1'b0;
        seen_sync = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tx_raw(1'b0, 1'b1, 1'b0);
            if (lk0 || lk1) seen_lock = 1'b1;
            if (st0 == 2'b01) seen_sync = 1'b1;
        end
        chk("t4_zero_nolock", {31'd0, seen_lock}, 32'd0);
        chk("t4_zero_sync", {31'd0, seen_sync}, 32'd1);

        // Constant one input never locks.
        do_reset();
        seen_lock = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tx_raw(1'b1, 1'b1, 1'b0);
            if (lk0 || lk1) seen_lock = 1'b1;
        end
        chk("t4_one_nolock", {31'd0, seen_lock}, 32'd0);

        // Random valid gaps: same lock point in valid bits.
        do_reset();
        acquire("t6", 50);
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(1) == 0);
            tx(1'($urandom_range(29) == 0), v, 1'($urandom_range(49) == 0));
        end
        for (int k = 0; k < 1000 && !lk0; k++) tx(1'b0, 1'($urandom), 1'b0);
        chk("t6_pre_rst_locked", {31'd0, lk0}, 32'd1);

        // Reset in the middle of LOCKED.
        rst_n = 1'b0;
        tx(1'b1, 1'b1, 1'b0);
        chk("t6_rst_state", {30'd0, st0}, 32'd0);
        chk("t6_rst_locked", {31'd0, lk0}, 32'd0);
        chk("t6_rst_pulse", {31'd0, ep0}, 32'd0);
        chk("t6_rst_count", {16'd0, ec0}, 32'd0);
        chk("t6_rst_count1", {28'd0, ec1}, 32'd0);
        rst_n = 1'b1;
        gen   = 31'h7FFF_FFFF;
        acquire("t6_after_rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
